// File: rtl/mem_if_pkg.sv
// Shared definitions for the controller <-> memory-responder command interface.
// Holds the responder state encoding, the rw encoding and the default bus
// widths so the controller FSM and the responder agree on them.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    ACCESS    = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  // Width of a down-counter that must hold (n - 1) for the larger of two
  // phase lengths; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Small storage array behind the memory responder.
//   clk     : clock, rising edge
//   rst     : synchronous active-high clear of every word
//   we      : write enable, write happens on the rising edge
//   addr    : word address shared by the read and write port
//   wdata   : write data
//   rd_data : combinational read of mem[addr]
module mem_array
  import mem_if_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: this array is deliberately cleared on reset (reads of unwritten
  // words must return 0), so it builds from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Target-side responder for the valid/rw command interface. Accepts one
// request at a time, runs PRECHARGE -> ACCESS (timed) -> RESP and commits a
// read or write to the internal array.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (aborts any request, clears array)
//   valid : request strobe, honoured only in IDLE
//   rw    : 1 = write, 0 = read, sampled with valid
//   addr  : word address, sampled with valid
//   wdata : write data, sampled with valid
//   rdata : read result, held until the next read completes
//   ack   : one-cycle completion pulse (RESP state)
//   busy  : high from the accept edge until RESP ends
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy
);

  localparam int CNT_W = cnt_width(READ_CYCLES, WRITE_CYCLES);
  localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_CYCLES - 1);

  state_t            state_q, state_d;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] arr_rd;
  logic              commit;
  logic              arr_we;

  // The operation commits on the last ACCESS edge, i.e. before RESP, so a
  // read issued right after a write sees the new data.
  assign commit = (state_q == ACCESS) && (cnt_q == '0);
  assign arr_we = commit && (rw_q == RW_WRITE);

  mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (arr_we),
    .addr   (addr_q),
    .wdata  (wdata_q),
    .rd_data(arr_rd)
  );

  // NOTE: sequential state uses non-blocking assignments only; the
  // combinational process below uses blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (valid) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
          end
        end
        PRECHARGE: cnt_q <= (rw_q == RW_WRITE) ? WRITE_LOAD : READ_LOAD;
        ACCESS: begin
          // Counter is only loaded in PRECHARGE, so it parks at 0 and
          // never wraps.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rw_q == RW_READ) begin
            rdata_q <= arr_rd;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (valid) state_d = PRECHARGE;
      PRECHARGE: state_d = ACCESS;
      ACCESS:    if (cnt_q == '0) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs come straight from registers: no input-to-output path.
  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_if_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, rw;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack, busy;

  // Second instance with single-cycle phases, driven independently.
  logic       s_valid, s_rw;
  logic [3:0] s_addr;
  logic [7:0] s_wdata;
  logic [7:0] s_rdata;
  logic       s_ack, s_busy;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;

  mem_responder #(
    .DATA_W(8), .ADDR_W(4), .READ_CYCLES(2), .WRITE_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .rw(rw), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy)
  );

  mem_responder #(
    .DATA_W(8), .ADDR_W(4), .READ_CYCLES(1), .WRITE_CYCLES(1)
  ) dut1 (
    .clk(clk), .rst(rst), .valid(s_valid), .rw(s_rw), .addr(s_addr),
    .wdata(s_wdata), .rdata(s_rdata), .ack(s_ack), .busy(s_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request to the main DUT (assumed idle) and return the number
  // of cycles from the accept edge to the ack cycle (0 on timeout).
  task automatic req(input logic r, input logic [3:0] a, input logic [7:0] d,
                     input bit perturb, output int lat);
    @(negedge clk);
    valid = 1'b1; rw = r; addr = a; wdata = d;
    @(posedge clk);
    #1 valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_after_accept", {31'd0, busy}, 32'd1);
      if (perturb && c == 1) begin
        rw = 1'b1; addr = 4'd9; wdata = 8'hEE;
      end
      if (ack) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic req1(input logic r, input logic [3:0] a, input logic [7:0] d,
                      output int lat);
    @(negedge clk);
    s_valid = 1'b1; s_rw = r; s_addr = a; s_wdata = d;
    @(posedge clk);
    #1 s_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (s_ack) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat, base, gap;
    int exp_gap [4] = '{5, 5, 6, 5};

    rst = 1'b1;
    valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    s_valid = 1'b0; s_rw = 1'b0; s_addr = '0; s_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ack",   {31'd0, ack},   32'd0);
    check("reset_busy",  {31'd0, busy},  32'd0);
    check("reset_rdata", {24'd0, rdata}, 32'h00);
    rst = 1'b0;

    // 1: read of a never-written address
    req(RW_READ, 4'd5, 8'h00, 1'b0, lat);
    check("rd5_latency", lat, 4);
    check("rd5_data", {24'd0, rdata}, 32'h00);

    // 2: write then read back
    req(RW_WRITE, 4'd3, 8'hA5, 1'b0, lat);
    check("wr3_latency", lat, 5);
    req(RW_READ, 4'd3, 8'h00, 1'b0, lat);
    check("rd3_latency", lat, 4);
    check("rd3_data", {24'd0, rdata}, 32'hA5);

    // 3: valid held high, alternating write/read of addr 7
    @(negedge clk);
    base = ack_cnt;
    valid = 1'b1; rw = RW_WRITE; addr = 4'd7; wdata = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      gap = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (ack) begin
          gap = c;
          break;
        end
      end
      check($sformatf("b2b_gap%0d", i), gap, exp_gap[i]);
      rw = (i % 2 == 0) ? RW_READ : RW_WRITE;
      if (i == 3) valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_ack_count", ack_cnt - base, 4);
    check("b2b_rdata", {24'd0, rdata}, 32'h3C);
    check("b2b_idle", {31'd0, busy}, 32'd0);

    // 4: inputs changed while busy are ignored
    req(RW_WRITE, 4'd2, 8'h11, 1'b0, lat);
    check("wr2_latency", lat, 5);
    @(negedge clk);
    base = ack_cnt;
    req(RW_READ, 4'd2, 8'h00, 1'b1, lat);
    check("rd2_latency", lat, 4);
    check("rd2_data", {24'd0, rdata}, 32'h11);
    @(negedge clk);
    check("rd2_no_extra_ack", {31'd0, ack}, 32'd0);
    check("rd2_ack_count", ack_cnt - base, 1);
    req(RW_READ, 4'd9, 8'h00, 1'b0, lat);
    check("rd9_data", {24'd0, rdata}, 32'h00);

    // 5: reset during a write's ACCESS phase
    req(RW_READ, 4'd2, 8'h00, 1'b0, lat);
    check("rd2_again", {24'd0, rdata}, 32'h11);
    @(negedge clk);
    base = ack_cnt;
    valid = 1'b1; rw = RW_WRITE; addr = 4'd1; wdata = 8'hFF;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (3) @(negedge clk);  // k+1 PRECHARGE, k+2/k+3 ACCESS
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'h00);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_ack", ack_cnt - base, 0);
    req(RW_READ, 4'd1, 8'h00, 1'b0, lat);
    check("rd1_latency", lat, 4);
    check("rd1_data", {24'd0, rdata}, 32'h00);
    req(RW_READ, 4'd2, 8'h00, 1'b0, lat);
    check("rd2_cleared", {24'd0, rdata}, 32'h00);

    // 6: single-cycle phases on the second instance
    check("s_reset_rdata", {24'd0, s_rdata}, 32'h00);
    req1(RW_WRITE, 4'd6, 8'h5A, lat);
    check("s_wr_latency", lat, 3);
    req1(RW_READ, 4'd6, 8'h00, lat);
    check("s_rd_latency", lat, 3);
    check("s_rd_data", {24'd0, s_rdata}, 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
